// File: rtl/mmio_bridge.sv
// mmio_bridge: single-outstanding CPU request bridge onto a simple MMIO peripheral bus
// with window/alignment/decode fault checking and fixed read latency.
module mmio_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter logic [31:0] WIN_MASK     = 32'h0000_FFFF,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_wstrb,
  output logic        per_read_en,
  input  logic [31:0] per_rdata,
  input  logic        per_addr_valid
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT, RESP} state_t;
  state_t      state_q;
  logic        we_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  cnt_q;
  logic        fault;
  // per_addr already carries the latched address during SETUP, so decode it directly
  assign fault = ((per_addr & ~WIN_MASK) != BASE_ADDR) || (per_addr[1:0] != 2'b00) || !per_addr_valid;
  assign req_ready = (state_q == IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      wstrb_q     <= 4'h0;
      cnt_q       <= 3'd0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0;
      per_addr    <= 32'h0;
      per_wdata   <= 32'h0;
      per_wstrb   <= 4'h0;
      per_read_en <= 1'b0;
    end else begin
      per_wstrb   <= 4'h0;
      per_read_en <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          per_addr  <= req_addr;
          per_wdata <= req_wdata;
          wstrb_q   <= req_wstrb;
          we_q      <= req_we;
          state_q   <= SETUP;
        end
        SETUP: if (fault) begin
          rsp_err   <= 1'b1;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end else begin
          per_wstrb   <= we_q ? wstrb_q : 4'h0;
          per_read_en <= !we_q;
          state_q     <= ACCESS;
        end
        ACCESS: if (we_q) begin
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end else begin
          cnt_q   <= 3'(READ_LATENCY);
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            rsp_rdata <= per_rdata;
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed checks of mmio_bridge timing, faults, stalls and reset abort.
module tb_mmio_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] per_addr;
  logic [31:0] per_wdata;
  logic [3:0]  per_wstrb;
  logic        per_read_en;
  logic [31:0] per_rdata = 32'h0;
  logic        per_addr_valid = 1'b1;
  logic [31:0] rd_val = 32'h0;
  int n_cmp = 0;
  int n_err = 0;

  mmio_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_wstrb(per_wstrb), .per_read_en(per_read_en),
    .per_rdata(per_rdata), .per_addr_valid(per_addr_valid)
  );

  always #5 clk = ~clk;

  // peripheral answers one cycle after the read strobe; garbage otherwise
  always @(posedge clk) per_rdata <= per_read_en ? rd_val : 32'hDEAD_BEEF;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, ".rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, ".per_addr"}, per_addr, 32'h0);
    check({tag, ".per_wdata"}, per_wdata, 32'h0);
    check({tag, ".per_wstrb"}, 32'(per_wstrb), 32'd0);
    check({tag, ".per_read_en"}, 32'(per_read_en), 32'd0);
  endtask

  task automatic txn(string tag, logic [31:0] addr, logic we, logic [31:0] wd, logic [3:0] ws,
                     logic pav, int lat, logic err, logic [31:0] rd, int stall, logic early);
    int n;
    req_addr = addr; req_we = we; req_wdata = wd; req_wstrb = ws;
    per_addr_valid = pav; rd_val = rd; rsp_ready = early;
    req_valid = 1'b1;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
    n = 1;
    while (1) begin
      check({tag, ".wstrb"}, 32'(per_wstrb), (n == 2 && !err && we) ? 32'(ws) : 32'd0);
      check({tag, ".rden"}, 32'(per_read_en), (n == 2 && !err && !we) ? 32'd1 : 32'd0);
      if (n == 2 && !err && we) check({tag, ".wdata"}, per_wdata, wd);
      if (n == 1) check({tag, ".per_addr"}, per_addr, addr);
      if (rsp_valid || n >= 20) break;
      cyc();
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(lat));
    check({tag, ".err"}, 32'(rsp_err), 32'(err));
    check({tag, ".rdata"}, rsp_rdata, (we || err) ? 32'h0 : rd);
    rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      cyc();
      check({tag, ".stall_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".stall_rdata"}, rsp_rdata, (we || err) ? 32'h0 : rd);
      check({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
      check({tag, ".stall_strobe"}, {27'h0, per_read_en, per_wstrb}, 32'h0);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".done_rdata"}, rsp_rdata, 32'h0);
    check({tag, ".done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2;
    check_reset_vals("reset");
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check_reset_vals("post_reset");

    txn("wr_basic", 32'h0200_4000, 1'b1, 32'h0000_0010, 4'hF, 1'b1, 3, 1'b0, 32'h0, 0, 1'b0);
    txn("rd_basic", 32'h0200_BFF8, 1'b0, 32'h0, 4'h0, 1'b1, 4, 1'b0, 32'h1234_5678, 0, 1'b0);
    txn("rd_nodec", 32'h0200_1000, 1'b0, 32'h0, 4'h0, 1'b0, 2, 1'b1, 32'h5555_AAAA, 0, 1'b0);
    txn("rd_misal", 32'h0200_4002, 1'b0, 32'h0, 4'h0, 1'b1, 2, 1'b1, 32'h5555_AAAA, 0, 1'b0);
    txn("wr_oow", 32'h0000_1000, 1'b1, 32'h1111_2222, 4'hF, 1'b1, 2, 1'b1, 32'h0, 0, 1'b0);
    txn("wr_after", 32'h0200_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1'b1, 3, 1'b0, 32'h0, 0, 1'b0);
    txn("wr_nostrb", 32'h0200_0008, 1'b1, 32'hFFFF_0000, 4'b0000, 1'b1, 3, 1'b0, 32'h0, 0, 1'b0);
    txn("rd_top", 32'h0200_FFFC, 1'b0, 32'h0, 4'h0, 1'b1, 4, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
    txn("rd_above", 32'h0201_0000, 1'b0, 32'h0, 4'h0, 1'b1, 2, 1'b1, 32'h0BAD_F00D, 0, 1'b0);
    txn("rd_stall", 32'h0200_0020, 1'b0, 32'h0, 4'h0, 1'b1, 4, 1'b0, 32'hC0DE_0042, 5, 1'b0);
    txn("rd_early", 32'h0200_0024, 1'b0, 32'h0, 4'h0, 1'b1, 4, 1'b0, 32'h7654_3210, 0, 1'b1);

    // reset pulse while the read sits in WAIT
    rd_val = 32'hCAFE_0001; per_addr_valid = 1'b1;
    req_addr = 32'h0200_0100; req_we = 1'b0; req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    cyc();
    check("abort.rden_access", 32'(per_read_en), 32'd1);
    cyc();
    check("abort.in_wait", {30'h0, rsp_valid, per_read_en}, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("abort.quiet", {27'h0, rsp_valid, per_read_en, 3'h0}, 32'h0);
      check("abort.wstrb", 32'(per_wstrb), 32'd0);
    end
    txn("rd_post", 32'h0200_0200, 1'b0, 32'h0, 4'h0, 1'b1, 4, 1'b0, 32'h9ABC_DEF0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
